// File: rtl/blit_write_buffer_if.sv
// Bus bundle for the blitter write buffer: the byte-write port from the
// blitter pipeline plus the burst-write port towards the SDRAM controller.
//
// Handshakes:
//   write side : a byte is taken on a clock edge where write_request is high
//                and write_stall is low; while stalled the producer holds
//                address/data unchanged.
//   burst side : mem_request stays high until the edge where mem_ack is seen;
//                afterwards each cycle with mem_wready high consumes the
//                presented mem_wdata/mem_wstrb word; mem_complete marks the
//                end of the burst.
interface blit_write_buffer_if #(
  parameter int ADDR_WIDTH = 26
);
  logic [ADDR_WIDTH-1:0] write_address;
  logic                  write_request;
  logic [7:0]            write_data;
  logic                  write_stall;
  logic                  flush;
  logic                  idle;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_request;
  logic                  mem_write;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_ack;
  logic                  mem_wready;
  logic                  mem_complete;

  // Buffer side.
  modport slave (
    input  write_address, write_request, write_data, flush,
    input  mem_ack, mem_wready, mem_complete,
    output write_stall, idle,
    output mem_address, mem_request, mem_write, mem_wdata, mem_wstrb
  );

  // Environment side (blitter pipeline + memory controller).
  modport master (
    output write_address, write_request, write_data, flush,
    output mem_ack, mem_wready, mem_complete,
    input  write_stall, idle,
    input  mem_address, mem_request, mem_write, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/blit_write_buffer.sv
// Write-combining buffer: gathers blitter byte writes into a 32-byte fill
// line and hands completed lines to a drain slot that issues 8-word burst
// writes with byte strobes. The blitter only stalls when it needs a new
// line while the drain slot is still busy.
module blit_write_buffer #(
  parameter int ADDR_WIDTH = 26,
  parameter int BURST_LEN  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  blit_write_buffer_if.slave   bus,
  output logic [1:0]           dbg_drain_state
);
  localparam int WORDS      = BURST_LEN;
  localparam int LINE_BYTES = 4 * BURST_LEN;
  localparam int TAG_W      = ADDR_WIDTH - 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_WAIT = 2'd3
  } drain_state_t;

  // Fill slot
  logic [31:0]           fill_data_q  [WORDS];
  logic [31:0]           fill_data_d  [WORDS];
  logic [LINE_BYTES-1:0] fill_be_q,  fill_be_d;
  logic [TAG_W-1:0]      fill_tag_q, fill_tag_d;
  logic                  flush_pending_q, flush_pending_d;

  // Drain slot (its tag lives on in mem_address)
  logic [31:0]           drain_data_q [WORDS];
  logic [31:0]           drain_data_d [WORDS];
  logic [LINE_BYTES-1:0] drain_be_q, drain_be_d;
  drain_state_t          state_q, state_d;
  logic [2:0]            wptr_q, wptr_d;
  logic                  mem_request_q, mem_request_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;

  // Decode of the incoming write
  logic [TAG_W-1:0] wr_tag;
  logic [2:0]       word_idx;
  logic [1:0]       lane;
  logic             fill_nonempty;
  logic             fill_full;
  logic             tag_match;
  logic             drain_busy;
  logic             evict;
  logic             handover;
  logic             accept;

  assign wr_tag        = bus.write_address[ADDR_WIDTH-1:5];
  assign word_idx      = bus.write_address[4:2];
  assign lane          = bus.write_address[1:0];
  assign fill_nonempty = |fill_be_q;
  assign fill_full     = &fill_be_q;
  assign tag_match     = (wr_tag == fill_tag_q);
  assign drain_busy    = (state_q != S_IDLE);

  // A line leaves the fill slot when a write wants another line, when it is
  // full, or when a flush is waiting; it can only move if drain is free.
  assign evict    = fill_nonempty &&
                    ((bus.write_request && !tag_match) || fill_full || flush_pending_q);
  assign handover = evict && !drain_busy;

  // A same-tag write into a full line also needs a fresh line, so it stalls
  // exactly like a tag miss while drain is busy.
  assign bus.write_stall = !reset && bus.write_request && fill_nonempty &&
                           (!tag_match || fill_full) && drain_busy;
  assign accept = bus.write_request && !bus.write_stall;

  assign bus.mem_request   = mem_request_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_write     = 1'b1;
  assign bus.mem_wdata     = drain_data_q[wptr_q];
  assign bus.mem_wstrb     = drain_be_q[{wptr_q, 2'b00} +: 4];
  assign bus.idle          = !fill_nonempty && (state_q == S_IDLE) && !flush_pending_q;
  assign dbg_drain_state   = state_q;

  // Fill/drain line contents: handover copies fill to drain, then the
  // accepted byte (if any) lands in the possibly freshly cleared fill line.
  always_comb begin
    fill_data_d  = fill_data_q;
    fill_be_d    = fill_be_q;
    fill_tag_d   = fill_tag_q;
    drain_data_d = drain_data_q;
    drain_be_d   = drain_be_q;
    if (handover) begin
      drain_data_d = fill_data_q;
      drain_be_d   = fill_be_q;
      fill_be_d    = '0;
    end
    if (accept) begin
      fill_data_d[word_idx][{lane, 3'b000} +: 8] = bus.write_data;
      fill_be_d[{word_idx, lane}]                = 1'b1;
      fill_tag_d                                 = wr_tag;
    end
    // A flush only means something while there is data to push.
    flush_pending_d = (flush_pending_q && !handover) || bus.flush;
    if (fill_be_d == '0) flush_pending_d = 1'b0;
  end

  // Drain FSM: request, 8 data beats, wait for completion.
  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    mem_request_d = mem_request_q;
    mem_address_d = mem_address_q;
    case (state_q)
      S_IDLE: begin
        if (handover) begin
          state_d       = S_REQ;
          mem_request_d = 1'b1;
          mem_address_d = {fill_tag_q, 5'b00000};
          wptr_d        = 3'd0;
        end
      end
      S_REQ: begin
        if (bus.mem_ack) begin
          mem_request_d = 1'b0;
          state_d       = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.mem_wready) begin
          wptr_d = wptr_q + 3'd1;
          if (wptr_q == 3'(WORDS - 1)) begin
            state_d = bus.mem_complete ? S_IDLE : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_complete) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state; reset abandons any burst in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill_be_q       <= '0;
      fill_tag_q      <= '0;
      flush_pending_q <= 1'b0;
      state_q         <= S_IDLE;
      wptr_q          <= 3'd0;
      mem_request_q   <= 1'b0;
      mem_address_q   <= '0;
    end else begin
      fill_be_q       <= fill_be_d;
      fill_tag_q      <= fill_tag_d;
      flush_pending_q <= flush_pending_d;
      state_q         <= state_d;
      wptr_q          <= wptr_d;
      mem_request_q   <= mem_request_d;
      mem_address_q   <= mem_address_d;
    end
  end

  // Line data is qualified by the enables, so it needs no reset.
  always_ff @(posedge clock) begin
    fill_data_q  <= fill_data_d;
    drain_data_q <= drain_data_d;
    drain_be_q   <= drain_be_d;
  end
endmodule

// File: doc/blit_write_buffer.md
Name: blit_write_buffer

Overview:
- Write-combining buffer between the blitter pixel write pipeline and the SDRAM burst port.
- Collects byte-wide pixel writes into a 32-byte line with per-byte enables. Completed lines are emitted as fixed-length 8-word burst writes with byte strobes.
- Two line slots: fill (accepting writes) and drain (being written to memory). The blitter stalls only when both are busy.
- Write-direction counterpart of the blitter read cache; uses the same address width and the same burst request/ack/complete handshake.

Parameters:
- ADDR_WIDTH, 26, byte address width.
- BURST_LEN, 8, words per burst (fixed at 8); line = 4*BURST_LEN bytes, tag = address[ADDR_WIDTH-1:5].

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- write_address  in  26  blitter byte address.
- write_request  in  1  byte write valid.
- write_data  in  8  pixel byte.
- write_stall  out  1  combinational; write not accepted this cycle, hold inputs.
- flush  in  1  one-cycle pulse; push the partial fill line to memory.
- idle  out  1  fill empty, drain idle, no flush pending.
- mem_address  out  26  burst base address, bits[4:0]=0.
- mem_request  out  1  burst write request, held until mem_ack.
- mem_write  out  1  constant 1.
- mem_wdata  out  32  current drain word (combinational from drain[wptr]).
- mem_wstrb  out  4  byte enables of the current drain word.
- mem_ack  in  1  request accepted.
- mem_wready  in  1  memory consumes mem_wdata/mem_wstrb this cycle.
- mem_complete  in  1  burst finished.

Behaviour:
- Reset (async): fill byte-enables=0, drain FSM=IDLE, wptr=0, flush_pending=0, mem_request=0, mem_address=0. In-flight burst is abandoned; the controller is reset by the same signal.
- Accept: write_request && !write_stall. The byte is stored at fill[addr[4:2]] lane addr[1:0], its enable set, tag=addr[25:5]. A later write to the same byte overwrites the earlier one.
- Eviction is needed when fill is nonempty and either:
  - the tag mismatches a new request,
  - all 32 enables are set, or
  - flush_pending is set.
- Handover, at a clock edge when eviction is needed and drain is IDLE:
  - fill data/enables/tag are copied to drain; fill enables are cleared; flush_pending is cleared.
  - The write accepted in the same cycle lands in the freshly cleared fill line. No stall on a line switch with a free drain.
- write_stall = write_request && fill nonempty && tag mismatch && drain != IDLE.
  - A same-tag write to a full line while drain is busy also stalls.
  - reset forces write_stall=0.
- flush sets flush_pending. Flush with an empty fill line is a no-op.
- Drain FSM:
  - IDLE: on handover go to REQ; mem_request<=1; mem_address<={tag,5'b0}; wptr<=0.
  - REQ: on mem_ack, mem_request<=0, go to DATA. mem_wready is ignored in REQ.
  - DATA: each mem_wready cycle consumes word wptr and increments wptr. All 8 words are sent, including words with mem_wstrb=0. After word 7 go to WAIT.
  - WAIT: on mem_complete go to IDLE. mem_complete arriving in the same cycle as word 7 goes directly to IDLE.
- Handover latency: the first mem_request is high one cycle after the triggering edge condition.
- Back-to-back: a new handover may occur in the same cycle drain returns to IDLE.
- idle is registered-state derived: (fill empty) && drain==IDLE && !flush_pending.

Test Plan:
- Reset, write 0xAB @0x000103, pulse flush:
  - mem_request rises with mem_address=0x000100.
  - Word0 has wstrb=4'b1000, wdata[31:24]=0xAB; words 1-7 have wstrb=0.
  - idle=1 after mem_complete.
- Sequential bytes 0x00..0x1F to 0x000200..0x00021F, no flush: auto-drain at the 32nd byte, all words wstrb=4'hF, word0=0x03020100, write_stall never asserted.
- Write 0x11 @0x40, 0x22 @0x40, 0x33 @0x41, flush: word0 wdata[15:0]=0x3322, wstrb=4'b0011.
- Line A write, line B write (handover, no stall), line C write while A's burst is unacked: write_stall=1 until A's mem_complete, then C accepted, then B is drained before C.
- Assert reset asynchronously during DATA after 3 wready beats: mem_request=0, idle=1 immediately, and the next flush of empty fill issues no request.
- flush with fill empty and drain IDLE: no mem_request, idle stays 1.
